// File: rtl/cordic_arbiter.sv
// Round-robin arbiter in front of a shared, pipelined cosine unit.
// Requesters post float32 angles. One request is granted per cycle and
// its angle is sent to the cosine unit. The requester index travels down
// a tag shift register that matches the pipeline depth, so each result
// returns to its owner. Responses come back in acceptance order.

module cordic_arbiter #(
   parameter int N_REQ   = 4,
   parameter int COS_LAT = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [32*N_REQ-1:0]  req_angle,
   output logic [N_REQ-1:0]     req_ready,
   output logic [31:0]          cos_angle,
   output logic                 cos_clk_en,
   input  logic [31:0]          cos_result,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [31:0]          rsp_result,
   output logic                 busy
);

   localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DRAIN
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [IDXW-1:0]   rrPtr_q;
   logic [31:0]       cosAngle_q;
   logic              cosClkEn_q;
   logic              busy_q;
   logic              issueValid_q;
   logic              tagValid_q [0:COS_LAT];
   logic [IDXW-1:0]   tagIdx_q   [0:COS_LAT];
   logic [N_REQ-1:0]  rspValid_q;
   logic [31:0]       rspResult_q;

   logic              accept;
   logic [IDXW-1:0]   grantIdx;
   logic [31:0]       selAngle;
   logic              inFlight;
   logic              anyReq;
   int                idx;

   assign anyReq = |req_valid;

   // Round-robin search from the pointer; only grants while ACTIVE and enabled
   always_comb begin
      req_ready = '0;
      grantIdx  = '0;
      accept    = 1'b0;
      selAngle  = '0;
      idx       = 0;
      if (state_q == ACTIVE && enable) begin
         for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rrPtr_q) + k) % N_REQ;
            if (!accept && req_valid[idx]) begin
               accept   = 1'b1;
               grantIdx = IDXW'(idx);
            end
         end
      end
      if (accept) begin
         req_ready[grantIdx] = 1'b1;
         selAngle            = req_angle[32*grantIdx +: 32];
      end
   end

   // Any work still travelling through the issue register or the tag pipe
   always_comb begin
      inFlight = issueValid_q;
      for (int k = 0; k <= COS_LAT; k++) begin
         inFlight = inFlight | tagValid_q[k];
      end
   end

   // Next-state selection; re-entering ACTIVE from DRAIN beats going idle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable && anyReq) state_d = ACTIVE;
         ACTIVE:  if (!accept) state_d = DRAIN;
         DRAIN: begin
            if (enable && anyReq)  state_d = ACTIVE;
            else if (!inFlight)    state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, issue register, tag pipe and response registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         rrPtr_q      <= '0;
         cosAngle_q   <= '0;
         cosClkEn_q   <= 1'b0;
         busy_q       <= 1'b0;
         issueValid_q <= 1'b0;
         for (int k = 0; k <= COS_LAT; k++) begin
            tagValid_q[k] <= 1'b0;
            tagIdx_q[k]   <= '0;
         end
         rspValid_q   <= '0;
         rspResult_q  <= '0;
      end else begin
         state_q      <= state_d;
         cosClkEn_q   <= (state_d != IDLE);
         busy_q       <= (state_d != IDLE);
         issueValid_q <= accept;
         if (accept) begin
            cosAngle_q <= selAngle;
            rrPtr_q    <= (int'(grantIdx) == N_REQ - 1) ? '0 : grantIdx + 1'b1;
         end
         tagValid_q[0] <= accept;
         tagIdx_q[0]   <= grantIdx;
         for (int k = 1; k <= COS_LAT; k++) begin
            tagValid_q[k] <= tagValid_q[k-1];
            tagIdx_q[k]   <= tagIdx_q[k-1];
         end
         if (tagValid_q[COS_LAT]) begin
            rspValid_q  <= {{(N_REQ-1){1'b0}}, 1'b1} << tagIdx_q[COS_LAT];
            rspResult_q <= cos_result;
         end else begin
            rspValid_q  <= '0;
         end
      end
   end

   assign cos_angle  = cosAngle_q;
   assign cos_clk_en = cosClkEn_q;
   assign busy       = busy_q;
   assign rsp_valid  = rspValid_q;
   assign rsp_result = rspResult_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a stand-in cosine pipeline.

module tb_cordic_arbiter;

   localparam int N   = 4;
   localparam int LAT = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic [N-1:0]      req_valid;
   logic [32*N-1:0]   req_angle;
   logic [N-1:0]      req_ready;
   logic [31:0]       cos_angle;
   logic              cos_clk_en;
   logic [31:0]       cos_result;
   logic [N-1:0]      rsp_valid;
   logic [31:0]       rsp_result;
   logic              busy;

   int                checks = 0;
   int                fails  = 0;
   logic [N-1:0]      expRsp [0:39];
   logic [31:0]       expRes [0:39];
   logic [31:0]       cosPipe [0:LAT-1];

   cordic_arbiter #(.N_REQ(N), .COS_LAT(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .req_valid  (req_valid),
      .req_angle  (req_angle),
      .req_ready  (req_ready),
      .cos_angle  (cos_angle),
      .cos_clk_en (cos_clk_en),
      .cos_result (cos_result),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Stand-in cosine: exact for angle 0, a traceable transform elsewhere
   function automatic logic [31:0] cosModel(input logic [31:0] a);
      return (a == 32'h0) ? 32'h3F80_0000 : (a ^ 32'h0F0F_0000);
   endfunction

   function automatic logic [31:0] angleOf(input int i);
      return 32'h4000_0000 + 32'(i) * 32'h0010_0000;
   endfunction

   // Cosine unit model: LAT register stages, cleared whenever clk_en is low
   always @(posedge clk) begin
      if (!cos_clk_en) begin
         for (int k = 0; k < LAT; k++) cosPipe[k] <= '0;
      end else begin
         cosPipe[0] <= cosModel(cos_angle);
         for (int k = 1; k < LAT; k++) cosPipe[k] <= cosPipe[k-1];
      end
   end
   assign cos_result = cosPipe[LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setAngle(input int i, input logic [31:0] a);
      req_angle[32*i +: 32] = a;
   endtask

   task automatic clearExp();
      for (int i = 0; i < 40; i++) begin
         expRsp[i] = '0;
         expRes[i] = '0;
      end
   endtask

   task automatic doReset();
      reset     = 1'b1;
      enable    = 1'b0;
      req_valid = '0;
      req_angle = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      checks++; if (req_ready  !== '0)    begin fails++; $display("[TB] FAIL reset_ready: got %b expected 0", req_ready); end
      checks++; if (rsp_valid  !== '0)    begin fails++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (rsp_result !== 32'h0) begin fails++; $display("[TB] FAIL reset_rsp_result: got %h expected 0", rsp_result); end
      checks++; if (cos_angle  !== 32'h0) begin fails++; $display("[TB] FAIL reset_cos_angle: got %h expected 0", cos_angle); end
      checks++; if (cos_clk_en !== 1'b0)  begin fails++; $display("[TB] FAIL reset_clk_en: got %b expected 0", cos_clk_en); end
      checks++; if (busy       !== 1'b0)  begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_single();
      doReset();
      enable    = 1'b1;
      setAngle(2, 32'h0);
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL single_idle_ready: got %b expected 0000", req_ready); end
      tick();
      checks++; if (busy !== 1'b1 || cos_clk_en !== 1'b1) begin fails++; $display("[TB] FAIL single_active: got busy=%b clk_en=%b expected 1 1", busy, cos_clk_en); end
      #1;
      checks++; if (req_ready !== 4'b0100) begin fails++; $display("[TB] FAIL single_grant: got %b expected 0100", req_ready); end
      tick();
      req_valid = '0;
      checks++; if (cos_angle !== 32'h0) begin fails++; $display("[TB] FAIL single_cos_angle: got %h expected 0", cos_angle); end
      for (int k = 1; k <= 3; k++) begin
         checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("[TB] FAIL single_early_rsp: got %b expected 0000 at t+%0d", rsp_valid, k); end
         tick();
      end
      checks++; if (rsp_valid !== 4'b0100) begin fails++; $display("[TB] FAIL single_rsp_valid: got %b expected 0100", rsp_valid); end
      checks++; if (rsp_result !== 32'h3F80_0000) begin fails++; $display("[TB] FAIL single_rsp_result: got %h expected 3f800000", rsp_result); end
      checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL single_drain_busy: got %b expected 1", busy); end
      tick();
      checks++; if (busy !== 1'b0 || cos_clk_en !== 1'b0 || rsp_valid !== '0) begin fails++; $display("[TB] FAIL single_idle: got busy=%b clk_en=%b rsp=%b expected 0 0 0000", busy, cos_clk_en, rsp_valid); end
   endtask

   task automatic test_round_robin();
      int gi;
      logic [N-1:0] expReady;
      doReset();
      clearExp();
      enable = 1'b1;
      for (int i = 0; i < N; i++) setAngle(i, angleOf(i));
      for (int c = 0; c < 14; c++) begin
         gi        = (c >= 1 && c <= 8) ? (c - 1) % N : -1;
         req_valid = (c <= 8) ? 4'b1111 : 4'b0000;
         #1;
         expReady = (gi >= 0) ? N'(1 << gi) : '0;
         checks++; if (req_ready !== expReady) begin fails++; $display("[TB] FAIL rr_grant c%0d: got %b expected %b", c, req_ready, expReady); end
         if (gi >= 0) begin
            expRsp[c+4] = expReady;
            expRes[c+4] = cosModel(angleOf(gi));
         end
         tick();
         checks++; if (rsp_valid !== expRsp[c+1]) begin fails++; $display("[TB] FAIL rr_rsp_valid c%0d: got %b expected %b", c + 1, rsp_valid, expRsp[c+1]); end
         if (expRsp[c+1] != '0) begin
            checks++; if (rsp_result !== expRes[c+1]) begin fails++; $display("[TB] FAIL rr_rsp_result c%0d: got %h expected %h", c + 1, rsp_result, expRes[c+1]); end
         end
      end
   endtask

   task automatic test_enable_drop();
      int gi;
      logic [N-1:0] expReady;
      logic expEn;
      doReset();
      clearExp();
      for (int i = 0; i < N; i++) setAngle(i, angleOf(i));
      req_valid = 4'b1111;
      for (int c = 0; c < 9; c++) begin
         enable = (c <= 2);
         gi     = (c == 1) ? 0 : (c == 2) ? 1 : -1;
         expEn  = (c >= 1 && c <= 6);
         #1;
         expReady = (gi >= 0) ? N'(1 << gi) : '0;
         checks++; if (req_ready !== expReady) begin fails++; $display("[TB] FAIL drop_grant c%0d: got %b expected %b", c, req_ready, expReady); end
         checks++; if (cos_clk_en !== expEn) begin fails++; $display("[TB] FAIL drop_clk_en c%0d: got %b expected %b", c, cos_clk_en, expEn); end
         if (gi >= 0) begin
            expRsp[c+4] = expReady;
            expRes[c+4] = cosModel(angleOf(gi));
         end
         tick();
         checks++; if (rsp_valid !== expRsp[c+1]) begin fails++; $display("[TB] FAIL drop_rsp_valid c%0d: got %b expected %b", c + 1, rsp_valid, expRsp[c+1]); end
         if (expRsp[c+1] != '0) begin
            checks++; if (rsp_result !== expRes[c+1]) begin fails++; $display("[TB] FAIL drop_rsp_result c%0d: got %h expected %h", c + 1, rsp_result, expRes[c+1]); end
         end
      end
      req_valid = '0;
   endtask

   task automatic test_reset_inflight();
      doReset();
      enable    = 1'b1;
      setAngle(0, angleOf(5));
      req_valid = 4'b0001;
      tick();
      #1;
      checks++; if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL rst_flight_grant: got %b expected 0001", req_ready); end
      tick();
      req_valid = '0;
      reset     = 1'b1;
      tick();
      reset     = 1'b0;
      checks++; if (busy !== 1'b0 || cos_clk_en !== 1'b0 || cos_angle !== 32'h0 || rsp_valid !== '0 || rsp_result !== 32'h0 || req_ready !== '0)
         begin fails++; $display("[TB] FAIL rst_flight_outputs: got busy=%b en=%b ang=%h rsp=%b res=%h rdy=%b expected all 0", busy, cos_clk_en, cos_angle, rsp_valid, rsp_result, req_ready); end
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++; if (rsp_valid !== '0) begin fails++; $display("[TB] FAIL rst_flight_rsp c%0d: got %b expected 0000", k, rsp_valid); end
      end
   endtask

   task automatic test_drain_reentry();
      int gi;
      logic [N-1:0] expReady;
      logic expEn;
      doReset();
      clearExp();
      enable = 1'b1;
      setAngle(0, angleOf(7));
      setAngle(3, angleOf(9));
      for (int c = 0; c < 11; c++) begin
         req_valid = (c <= 1) ? 4'b0001 : (c == 3 || c == 4) ? 4'b1000 : 4'b0000;
         gi        = (c == 1) ? 0 : (c == 4) ? 3 : -1;
         expEn     = (c >= 1 && c <= 8);
         #1;
         expReady = (gi >= 0) ? N'(1 << gi) : '0;
         checks++; if (req_ready !== expReady) begin fails++; $display("[TB] FAIL reentry_grant c%0d: got %b expected %b", c, req_ready, expReady); end
         checks++; if (cos_clk_en !== expEn) begin fails++; $display("[TB] FAIL reentry_clk_en c%0d: got %b expected %b", c, cos_clk_en, expEn); end
         if (gi >= 0) begin
            expRsp[c+4] = expReady;
            expRes[c+4] = cosModel(angleOf(gi == 0 ? 7 : 9));
         end
         tick();
         checks++; if (rsp_valid !== expRsp[c+1]) begin fails++; $display("[TB] FAIL reentry_rsp_valid c%0d: got %b expected %b", c + 1, rsp_valid, expRsp[c+1]); end
         if (expRsp[c+1] != '0) begin
            checks++; if (rsp_result !== expRes[c+1]) begin fails++; $display("[TB] FAIL reentry_rsp_result c%0d: got %h expected %h", c + 1, rsp_result, expRes[c+1]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] expReady;
      doReset();
      clearExp();
      enable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         req_valid = (c <= 3) ? 4'b0010 : 4'b0000;
         setAngle(1, angleOf(c == 0 ? 10 : 9 + c));
         #1;
         expReady = (c >= 1 && c <= 3) ? 4'b0010 : 4'b0000;
         checks++; if (req_ready !== expReady) begin fails++; $display("[TB] FAIL b2b_grant c%0d: got %b expected %b", c, req_ready, expReady); end
         if (c >= 1 && c <= 3) begin
            expRsp[c+4] = 4'b0010;
            expRes[c+4] = cosModel(angleOf(9 + c));
         end
         tick();
         checks++; if (rsp_valid !== expRsp[c+1]) begin fails++; $display("[TB] FAIL b2b_rsp_valid c%0d: got %b expected %b", c + 1, rsp_valid, expRsp[c+1]); end
         if (expRsp[c+1] != '0) begin
            checks++; if (rsp_result !== expRes[c+1]) begin fails++; $display("[TB] FAIL b2b_rsp_result c%0d: got %h expected %h", c + 1, rsp_result, expRes[c+1]); end
         end
      end
   endtask

   // Run each scenario in turn, then report
   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_enable_drop();
      test_reset_inflight();
      test_drain_reentry();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // Guard against a stuck simulation
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
